// File: rtl/rg_arb_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
// State codes are fixed numeric values so the debug port decodes the same everywhere.
package rg_arb_pkg;

   localparam int RG_W      = 3;
   localparam int N_REQ_MAX = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      WRITE = ST_WRITE,
      ACK   = ST_ACK
   } state_e;

endpackage

// File: rtl/rg.sv
// The shared W-bit storage register with its own synchronous clear and load enable.
module rg #(
   parameter int W = 3
) (
   input  logic         CLK,
   input  logic [W-1:0] D,
   input  logic         RST,
   input  logic         EN,
   output logic [W-1:0] Q
);

   always_ff @(posedge CLK) begin
      if (RST) begin
         Q <= '0;
      end else if (EN) begin
         Q <= D;
      end
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   int   j;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = |req_i;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/rg_wr_arbiter.sv
// Round-robin arbiter serialising requester writes into one shared register
// with a REQ/GNT four-phase handshake and a wrapping completion counter.
module rg_wr_arbiter
   import rg_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = RG_W,
   parameter int CNT_W = 8,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_REQ-1:0]   REQ,
   input  logic [N_REQ*W-1:0] WDATA,
   output logic [N_REQ-1:0]   GNT,
   output logic [W-1:0]       Q,
   output logic               BUSY,
   output logic [IW-1:0]      LAST_ID,
   output logic [CNT_W-1:0]   WR_CNT,
   output logic [1:0]         DBG_STATE
);

   // Handshake: a requester raises REQ[i] with WDATA slot i valid and holds it
   // until GNT[i]; GNT[i] then stays high until REQ[i] is sampled low.

   state_e             state_q, state_d;
   logic [IW-1:0]      win_q, win_d;
   logic [W-1:0]       data_q, data_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]      last_q, last_d;

   logic [W-1:0]       wdata_a [N_REQ];
   logic [N_REQ-1:0]   pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_vld;
   logic               rg_en;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign wdata_a[g] = WDATA[g*W +: W];
   end

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (REQ),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .vld_o (pick_vld)
   );

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      rg_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               win_d   = pick_idx;
               data_d  = wdata_a[pick_idx];
               state_d = WRITE;
            end
         end
         WRITE: begin
            rg_en   = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            last_d  = win_q;
            ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
            state_d = ACK;
         end
         ACK: begin
            if (!REQ[win_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         win_q   <= '0;
         data_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         data_q  <= data_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // The register sees RST directly so a write cut short by reset never lands.
   rg #(
      .W (W)
   ) u_rg (
      .CLK (CLK),
      .D   (data_q),
      .RST (RST),
      .EN  (rg_en),
      .Q   (Q)
   );

   always_comb begin
      GNT = '0;
      if (state_q == ACK) begin
         GNT[win_q] = 1'b1;
      end
   end

   assign BUSY      = (state_q != IDLE);
   assign LAST_ID   = last_q;
   assign WR_CNT    = cnt_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_rg_wr_arbiter.sv
// Bench for rg_wr_arbiter: directed handshake scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_rg_wr_arbiter;

   localparam int N     = 4;
   localparam int W     = 3;
   localparam int CNT_W = 8;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic           busy;
   logic [1:0]     last_id;
   logic [CNT_W-1:0] wr_cnt;
   logic [1:0]     dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: a write is "pending" from arbitration until its ACK exit;
   // m_age counts edges since arbitration
   logic [W-1:0]     m_q;
   logic [CNT_W-1:0] m_cnt;
   int               m_last, m_ptr, m_win, m_age;
   logic [W-1:0]     m_data;
   bit               m_pend;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [31:0] val_q[$];

   rg_wr_arbiter #(.N_REQ(N), .W(W), .CNT_W(CNT_W)) dut (
      .CLK       (clk),
      .RST       (rst),
      .REQ       (req),
      .WDATA     (wdata),
      .GNT       (gnt),
      .Q         (q),
      .BUSY      (busy),
      .LAST_ID   (last_id),
      .WR_CNT    (wr_cnt),
      .DBG_STATE (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_q = '0; m_cnt = '0; m_last = 0; m_ptr = 0;
         m_pend = 0; m_age = 0; m_win = 0; m_data = '0;
      end else if (!m_pend) begin
         if (req != '0) begin
            for (int k = 0; k < N; k++) begin
               if (!m_pend && req[(m_ptr + k) % N]) begin
                  m_win  = (m_ptr + k) % N;
                  m_pend = 1;
               end
            end
            m_data = wdata[m_win*W +: W];
            m_age  = 0;
         end
      end else begin
         m_age++;
         if (m_age == 1) begin
            m_q    = m_data;
            m_cnt  = m_cnt + 1'b1;
            m_last = m_win;
            m_ptr  = (m_win + 1) % N;
         end else if (!req[m_win]) begin
            m_pend = 0;
         end
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] e_gnt;
      logic [1:0]   e_st;
      e_gnt = '0;
      if (m_pend && m_age >= 1) e_gnt[m_win] = 1'b1;
      e_st = !m_pend ? 2'd0 : (m_age == 0 ? 2'd1 : 2'd2);
      check("q",       32'(q),         32'(m_q));
      check("gnt",     32'(gnt),       32'(e_gnt));
      check("busy",    32'(busy),      32'(m_pend));
      check("last_id", 32'(last_id),   32'(m_last));
      check("wr_cnt",  32'(wr_cnt),    32'(m_cnt));
      check("state",   32'(dbg_state), 32'(e_st));
   endtask

   // one clock: model consumes the inputs set now, DUT samples them at the edge
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   // single requester write; WDATA slot is scrambled after arbitration
   task automatic do_write(input int id, input logic [W-1:0] d, input int hold);
      bit seen;
      seen = 0;
      req[id] = 1'b1;
      wdata[id*W +: W] = d;
      for (int c = 0; c < 10 && !seen; c++) begin
         cycle();
         wdata[id*W +: W] = W'($urandom_range(0, 7));
         if (gnt[id]) seen = 1;
      end
      if (!seen) check("write_timeout", 32'd0, 32'd1);
      for (int h = 0; h < hold; h++) cycle();
      req[id] = 1'b0;
      cycle();
   endtask

   // serve all currently raised requests, each dropping REQ on its GNT
   task automatic serve_all(input int max_cycles);
      got_q.delete();
      val_q.delete();
      for (int c = 0; c < max_cycles && req != '0; c++) begin
         cycle();
         for (int i = 0; i < N; i++) begin
            if (gnt[i] && req[i]) begin
               got_q.push_back(32'(i));
               val_q.push_back(32'(q));
               req[i] = 1'b0;
            end
         end
      end
      if (req != '0) check("serve_timeout", 32'(req), 32'd0);
      cycle();
   endtask

   task automatic compare_queues(input string tag, input logic [31:0] got[$]);
      check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check(tag, got[i], exp_q[i]);
      end
   endtask

   initial begin
      logic [W-1:0] last_d;
      int hold [N];
      m_q = '0; m_cnt = '0; m_last = 0; m_ptr = 0;
      m_pend = 0; m_age = 0; m_win = 0; m_data = '0;
      rst = 1'b1;
      req = N'($urandom_range(0, 15));
      wdata = '0;

      // 1: reset with random requests
      cycle();
      req = N'($urandom_range(0, 15));
      cycle();
      check("rst_q", 32'(q), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_cnt", 32'(wr_cnt), 32'd0);
      rst = 1'b0;
      req = '0;
      cycle();

      // 2: single write held three extra cycles
      do_write(0, 3'b101, 3);
      check("t2_q", 32'(q), 32'h5);
      check("t2_cnt", 32'(wr_cnt), 32'd1);

      // winner drops REQ during WRITE: still commits, ACK lasts one cycle
      req = 4'b0010;
      wdata[1*W +: W] = 3'b110;
      cycle();
      req = '0;
      cycle();
      check("drop_gnt", 32'(gnt), 32'h2);
      check("drop_q", 32'(q), 32'h6);
      cycle();
      check("drop_gnt_off", 32'(gnt), 32'h0);
      check("drop_busy", 32'(busy), 32'h0);

      // 3: all four request at once
      do_reset();
      wdata = {3'd4, 3'd3, 3'd2, 3'd1};
      req = 4'b1111;
      serve_all(60);
      exp_q = {32'd0, 32'd1, 32'd2, 32'd3};
      compare_queues("t3_order", got_q);
      exp_q = {32'd1, 32'd2, 32'd3, 32'd4};
      compare_queues("t3_q", val_q);
      check("t3_cnt", 32'(wr_cnt), 32'd4);

      // 4: after a grant to 2 the pointer is 3, so 0 wins over 2
      do_reset();
      req = 4'b0100;
      serve_all(20);
      req = 4'b0101;
      wdata = {N*W{1'b1}};
      serve_all(40);
      exp_q = {32'd0, 32'd2};
      compare_queues("t4_order", got_q);
      check("t4_last", 32'(last_id), 32'd2);

      // 5: reset lands during WRITE
      do_reset();
      req = 4'b0001;
      wdata[0 +: W] = 3'b111;
      cycle();
      check("t5_in_write", 32'(dbg_state), 32'd1);
      rst = 1'b1;
      req = '0;
      cycle();
      rst = 1'b0;
      check("t5_q", 32'(q), 32'd0);
      check("t5_gnt", 32'(gnt), 32'd0);
      check("t5_cnt", 32'(wr_cnt), 32'd0);
      check("t5_state", 32'(dbg_state), 32'd0);
      cycle();
      check("t5_q_after", 32'(q), 32'd0);

      // 6: 256 writes wrap the counter
      last_d = '0;
      for (int n = 0; n < 256; n++) begin
         last_d = W'($urandom_range(0, 7));
         do_write(1, last_d, 0);
      end
      check("t6_cnt_wrap", 32'(wr_cnt), 32'd0);
      check("t6_q", 32'(q), 32'(last_d));

      // random traffic with occasional reset
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  hold[i] = $urandom_range(0, 2);
               end
            end else if (gnt[i]) begin
               if (hold[i] == 0) req[i] = 1'b0;
               else hold[i]--;
            end
         end
         wdata = (N*W)'($urandom_range(0, 4095));
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
